// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: interrupt FSM states,
// forwarding select encodings, register-address width and the forwarding mux rule.
package hazard_ctrl_pkg;

  localparam int REG_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PUSH_HI = 3'd2,
    ST_PUSH_LO = 3'd3,
    ST_VECTOR  = 3'd4
  } int_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX wins over MEM; a load in EX cannot forward (its data is not ready yet).
  function automatic logic [1:0] fwd_sel(
    input logic             ex_w,
    input logic             ex_mr,
    input logic [REG_W-1:0] ex_d,
    input logic             mem_w,
    input logic [REG_W-1:0] mem_d,
    input logic [REG_W-1:0] src
  );
    if (ex_w && !ex_mr && (ex_d == src)) return FWD_EX;
    else if (mem_w && (mem_d == src))    return FWD_MEM;
    else                                 return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_int_seq.sv
// Interrupt sequencer: pending flag, drain counter and the
// IDLE -> DRAIN -> PUSH_HI -> PUSH_LO -> VECTOR service FSM.
module hazard_int_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int INT_DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  output int_state_t state,
  output logic       drain,
  output logic       push,
  output logic       word_sel,
  output logic       load_pc,
  output logic       ack
);

  localparam int CW = (INT_DRAIN_CYCLES > 1) ? $clog2(INT_DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(INT_DRAIN_CYCLES - 1);

  int_state_t    state_next;
  logic          pending;
  logic          pending_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          req_seen;

  // A request on the same cycle as IDLE starts service without waiting a cycle.
  assign req_seen = pending | int_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = req_seen;
    case (state)
      ST_IDLE: begin
        if (req_seen) begin
          state_next   = ST_DRAIN;
          cnt_next     = CNT_LOAD;
          pending_next = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) state_next = ST_PUSH_HI;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_PUSH_HI: state_next = ST_PUSH_LO;
      ST_PUSH_LO: state_next = ST_VECTOR;
      ST_VECTOR:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    drain    = 1'b0;
    push     = 1'b0;
    word_sel = 1'b0;
    load_pc  = 1'b0;
    ack      = 1'b0;
    case (state)
      ST_DRAIN:   drain = 1'b1;
      ST_PUSH_HI: begin
        push     = 1'b1;
        word_sel = 1'b1;
      end
      ST_PUSH_LO: push = 1'b1;
      ST_VECTOR: begin
        load_pc = 1'b1;
        ack     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding
// and interrupt sequencing. Define HAZARD_FWD_EN to enable forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int INT_DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_uses1,
  input  logic             id_uses2,
  input  logic [REG_W-1:0] id_rsrc1,
  input  logic [REG_W-1:0] id_rsrc2,
  input  logic             ex_regWrite,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rdst,
  input  logic             mem_regWrite,
  input  logic [REG_W-1:0] mem_rdst,
  input  logic             branch_taken,
  input  logic             int_req,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             int_push,
  output logic             int_word_sel,
  output logic             int_load_pc,
  output logic             int_ack
);

  int_state_t int_state;
  logic       seq_drain;
  logic       seq_push;
  logic       seq_word_sel;
  logic       seq_load_pc;
  logic       seq_ack;
  logic       int_hold;
  logic       load_stall;
  logic       raw_stall;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  hazard_int_seq #(
    .INT_DRAIN_CYCLES(INT_DRAIN_CYCLES)
  ) u_int_seq (
    .clk      (clk),
    .rst      (rst),
    .int_req  (int_req),
    .state    (int_state),
    .drain    (seq_drain),
    .push     (seq_push),
    .word_sel (seq_word_sel),
    .load_pc  (seq_load_pc),
    .ack      (seq_ack)
  );

  assign load_stall = id_valid & ex_memRead & ex_regWrite &
                      ((id_uses1 & (id_rsrc1 == ex_rdst)) |
                       (id_uses2 & (id_rsrc2 == ex_rdst)));

`ifdef HAZARD_FWD_EN
  assign fwd_a_sel = fwd_sel(ex_regWrite, ex_memRead, ex_rdst, mem_regWrite, mem_rdst, id_rsrc1);
  assign fwd_b_sel = fwd_sel(ex_regWrite, ex_memRead, ex_rdst, mem_regWrite, mem_rdst, id_rsrc2);
  assign raw_stall = 1'b0;
`else
  // No bypass paths: any in-flight producer of a source must stall decode.
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
  assign raw_stall = id_valid &
    ((id_uses1 & ((ex_regWrite  & (id_rsrc1 == ex_rdst)) |
                  (mem_regWrite & (id_rsrc1 == mem_rdst)))) |
     (id_uses2 & ((ex_regWrite  & (id_rsrc2 == ex_rdst)) |
                  (mem_regWrite & (id_rsrc2 == mem_rdst)))));
`endif

  // A taken branch squashes the decode instruction, so its hazard is moot.
  assign stall    = (load_stall | raw_stall) & ~branch_taken;
  assign int_hold = (int_state != ST_IDLE) && (int_state != ST_VECTOR);

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    int_push     = 1'b0;
    int_word_sel = 1'b0;
    int_load_pc  = 1'b0;
    int_ack      = 1'b0;
    if (!rst) begin
      pc_stall     = stall | int_hold;
      ifid_stall   = stall;
      ifid_flush   = branch_taken | seq_drain;
      idex_bubble  = load_stall | raw_stall | branch_taken;
      fwd_a        = fwd_a_sel;
      fwd_b        = fwd_b_sel;
      int_push     = seq_push;
      int_word_sel = seq_word_sel;
      int_load_pc  = seq_load_pc;
      int_ack      = seq_ack;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases plus random traffic,
// scored against a cycle-indexed reference model through an expected queue.
module tb_hazard_ctrl;

  localparam int D = 2;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       u1;
    logic       u2;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       exw;
    logic       exmr;
    logic [2:0] exd;
    logic       memw;
    logic [2:0] memd;
    logic       br;
    logic       irq;
  } stim_t;

  logic       clk;
  logic       rst;
  logic       id_valid, id_uses1, id_uses2;
  logic [2:0] id_rsrc1, id_rsrc2;
  logic       ex_regWrite, ex_memRead;
  logic [2:0] ex_rdst;
  logic       mem_regWrite;
  logic [2:0] mem_rdst;
  logic       branch_taken, int_req;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       int_push, int_word_sel, int_load_pc, int_ack;

  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  // Model: the interrupt service is a window of D+3 cycles starting at m_start.
  bit          m_pend  = 1'b0;
  int          m_start = -1;

  hazard_ctrl #(.INT_DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_uses1(id_uses1), .id_uses2(id_uses2),
    .id_rsrc1(id_rsrc1), .id_rsrc2(id_rsrc2),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_rdst(ex_rdst),
    .mem_regWrite(mem_regWrite), .mem_rdst(mem_rdst),
    .branch_taken(branch_taken), .int_req(int_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .int_push(int_push), .int_word_sel(int_word_sel),
    .int_load_pc(int_load_pc), .int_ack(int_ack)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst:1'b0, valid:1'b0, u1:1'b0, u2:1'b0, r1:3'd0, r2:3'd0, exw:1'b0,
          exmr:1'b0, exd:3'd0, memw:1'b0, memd:3'd0, br:1'b0, irq:1'b0};
    return s;
  endfunction

  function automatic logic [1:0] model_fwd(input stim_t s, input logic [2:0] src);
`ifdef HAZARD_FWD_EN
    if (s.exw && !s.exmr && s.exd == src) return 2'b01;
    if (s.memw && s.memd == src)          return 2'b10;
`endif
    return 2'b00;
  endfunction

  // Driver: apply one cycle of inputs and push the model's expected outputs.
  task automatic step(input stim_t s, input string tag);
    logic [11:0] e;
    bit ld, raw, stall, drn, phi, plo, vec, in_serv;
    int ph;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.valid; id_uses1 = s.u1; id_uses2 = s.u2;
    id_rsrc1 = s.r1; id_rsrc2 = s.r2; ex_regWrite = s.exw; ex_memRead = s.exmr;
    ex_rdst = s.exd; mem_regWrite = s.memw; mem_rdst = s.memd;
    branch_taken = s.br; int_req = s.irq;
    if (s.rst) begin
      e = '0;
      m_pend  = 1'b0;
      m_start = -1;
    end else begin
      ph  = (m_start >= 0) ? (cyc - m_start) : -1;
      drn = (ph >= 0) && (ph < D);
      phi = (ph == D);
      plo = (ph == D + 1);
      vec = (ph == D + 2);
      in_serv = (ph >= 0) && (ph <= D + 2);
      ld = s.valid && s.exmr && s.exw &&
           ((s.u1 && s.r1 == s.exd) || (s.u2 && s.r2 == s.exd));
      raw = 1'b0;
`ifndef HAZARD_FWD_EN
      raw = s.valid &&
            ((s.u1 && ((s.exw && s.r1 == s.exd) || (s.memw && s.r1 == s.memd))) ||
             (s.u2 && ((s.exw && s.r2 == s.exd) || (s.memw && s.r2 == s.memd))));
`endif
      stall = (ld || raw) && !s.br;
      e = {stall || drn || phi || plo, stall, s.br || drn, ld || raw || s.br,
           model_fwd(s, s.r1), model_fwd(s, s.r2), phi || plo, phi, vec, vec};
      if (!in_serv && (m_pend || s.irq)) begin
        m_start = cyc + 1;
        m_pend  = 1'b0;
      end else if (in_serv) begin
        m_pend = m_pend || s.irq;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    cyc_q.push_back(cyc);
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(idle_stim(), tag);
  endtask

  // Scoreboard monitor: compare on the falling edge, away from the active edge.
  initial begin
    logic [11:0] got, e;
    string t;
    int c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        c = cyc_q.pop_front();
        got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b,
               int_push, int_word_sel, int_load_pc, int_ack};
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%b expected=%b", t, c, got, e);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_valid = 0; id_uses1 = 0; id_uses2 = 0; id_rsrc1 = 0; id_rsrc2 = 0;
    ex_regWrite = 0; ex_memRead = 0; ex_rdst = 0; mem_regWrite = 0; mem_rdst = 0;
    branch_taken = 0; int_req = 0;

    s = idle_stim(); s.rst = 1'b1; s.valid = 1'b1; s.br = 1'b1;
    step(s, "reset_outputs_zero");
    step(s, "reset_outputs_zero");
    idle_cycles(2, "idle_after_reset");

    s = idle_stim(); s.valid = 1; s.exmr = 1; s.exw = 1; s.exd = 3; s.r1 = 3; s.u1 = 1;
    step(s, "load_use");

    s = idle_stim(); s.valid = 1; s.u2 = 1; s.exd = 2; s.memd = 2; s.exw = 1; s.memw = 1; s.r2 = 2;
    step(s, "fwd_ex_priority");
    s.exw = 0;
    step(s, "fwd_mem");

    s = idle_stim(); s.valid = 1; s.exmr = 1; s.exw = 1; s.exd = 4; s.r2 = 4; s.u2 = 1; s.br = 1;
    step(s, "branch_over_load_use");

    s = idle_stim(); s.irq = 1;
    step(s, "int_req");
    idle_cycles(6, "int_sequence");

    step(s, "int_req_first");
    idle_cycles(2, "int_drain");
    step(s, "int_req_in_push_hi");
    idle_cycles(12, "int_second_service");

    step(s, "int_req_then_reset");
    idle_cycles(1, "int_drain_pre_reset");
    s = idle_stim(); s.rst = 1; s.irq = 1;
    step(s, "reset_mid_drain");
    idle_cycles(8, "no_ack_after_reset");

    s = idle_stim(); s.valid = 1; s.memw = 1; s.memd = 5; s.r1 = 5; s.u1 = 1;
    step(s, "mem_raw");

    s = idle_stim(); s.irq = 1;
    step(s, "int_req_branch");
    s = idle_stim(); s.br = 1;
    step(s, "branch_in_drain");
    idle_cycles(7, "int_after_branch");

    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 79) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.u1    = $urandom_range(0, 1);
      s.u2    = $urandom_range(0, 1);
      s.r1    = 3'($urandom_range(0, 3));
      s.r2    = 3'($urandom_range(0, 3));
      s.exw   = $urandom_range(0, 1);
      s.exmr  = ($urandom_range(0, 2) == 0);
      s.exd   = 3'($urandom_range(0, 3));
      s.memw  = $urandom_range(0, 1);
      s.memd  = 3'($urandom_range(0, 3));
      s.br    = ($urandom_range(0, 5) == 0);
      s.irq   = ($urandom_range(0, 11) == 0);
      step(s, "random");
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter INT_DRAIN_CYCLES, default 2, meaning the number of pipeline drain cycles before an interrupt push.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports id_valid in 1, id_uses1 in 1, id_uses2 in 1, id_rsrc1 in 3, id_rsrc2 in 3: the decode-stage instruction and its source registers.
REQ-005 SHALL have ports ex_regWrite in 1, ex_memRead in 1, ex_rdst in 3: the execute-stage destination.
REQ-006 SHALL have ports mem_regWrite in 1, mem_rdst in 3: the memory-stage destination.
REQ-007 SHALL have ports branch_taken in 1 (resolved in EX) and int_req in 1 (single-cycle pulse).
REQ-008 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_bubble, each out 1.
REQ-009 SHALL have outputs fwd_a and fwd_b, each out 2: 00 = register file, 01 = EX result, 10 = MEM result.
REQ-010 SHALL have outputs int_push out 1, int_word_sel out 1 (1 = PC high word), int_load_pc out 1 and int_ack out 1.

Function
REQ-011 SHALL assert load_stall combinationally when id_valid & ex_memRead & ex_regWrite and (id_uses1 & id_rsrc1==ex_rdst, or id_uses2 & id_rsrc2==ex_rdst).
REQ-012 load_stall SHALL drive pc_stall=1, ifid_stall=1 and idex_bubble=1 in the same cycle, with zero latency.
REQ-013 fwd_a SHALL be 01 if ex_regWrite & !ex_memRead & ex_rdst==id_rsrc1, else 10 if mem_regWrite & mem_rdst==id_rsrc1, else 00; EX SHALL take priority over MEM.
REQ-014 fwd_b SHALL follow the REQ-013 rule using id_rsrc2.
REQ-015 branch_taken SHALL assert ifid_flush=1 and idex_bubble=1 that cycle and SHALL suppress load_stall (pc_stall=0, ifid_stall=0).
REQ-016 An int_req pulse SHALL set a pending flag; a pulse while pending is already set SHALL be absorbed, giving one service.
REQ-017 The FSM states SHALL be IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR.
REQ-018 FSM transition: IDLE -> DRAIN when pending=1; the drain counter SHALL load INT_DRAIN_CYCLES-1.
REQ-019 FSM transition: DRAIN -> PUSH_HI when the counter reaches 0; otherwise the counter SHALL decrement.
REQ-020 FSM transitions: PUSH_HI -> PUSH_LO -> VECTOR -> IDLE, one cycle each.
REQ-021 pending SHALL clear on entry to DRAIN; a new int_req arriving in DRAIN through VECTOR SHALL set pending and be serviced after IDLE.
REQ-022 In DRAIN: pc_stall=1 and ifid_flush=1; hazard logic SHALL still drive idex_bubble and fwd_*.
REQ-023 In PUSH_HI: int_push=1, int_word_sel=1, pc_stall=1.
REQ-024 In PUSH_LO: int_push=1, int_word_sel=0, pc_stall=1.
REQ-025 In VECTOR: int_load_pc=1 and int_ack=1 for exactly one cycle.
REQ-026 branch_taken during DRAIN SHALL flush per REQ-015 and SHALL NOT alter the FSM sequence.
REQ-027 Total interrupt service latency SHALL be INT_DRAIN_CYCLES+3 cycles, from the first DRAIN cycle to the VECTOR cycle inclusive.

Reset
REQ-028 rst SHALL force state=IDLE, pending=0 and counter=0 immediately, independent of clk.
REQ-029 While rst=1, every output SHALL be 0.
REQ-030 Reset asserted in any FSM state SHALL abandon the interrupt without int_ack.

Configuration
REQ-031 With HAZARD_FWD_EN defined, forwarding SHALL behave per REQ-013/014.
REQ-032 Without HAZARD_FWD_EN, fwd_a and fwd_b SHALL be tied to 00.
REQ-033 Without HAZARD_FWD_EN, a stall SHALL also occur on any RAW match against ex_rdst with ex_regWrite, or against mem_rdst with mem_regWrite, using REQ-012 outputs.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the fwd select encodings (FWD_RF, FWD_EX, FWD_MEM) and the register-address width constant.
REQ-035 A single sub-module, hazard_int_seq, SHALL contain the interrupt FSM, pending flag and drain counter; hazard and forwarding logic SHALL remain in the top.

Verification
REQ-036 Load-use: ex_memRead=1, ex_regWrite=1, ex_rdst=3, id_rsrc1=3, id_uses1=1 -> pc_stall=ifid_stall=idex_bubble=1; fwd_a=00.
REQ-037 Forward priority: ex_rdst=mem_rdst=2, both regWrite=1, id_rsrc2=2, ex_memRead=0 -> fwd_b=01; drop ex_regWrite -> fwd_b=10.
REQ-038 Branch + load-use same cycle -> ifid_flush=1, idex_bubble=1, pc_stall=0.
REQ-039 int_req pulse at cycle 0, INT_DRAIN_CYCLES=2 -> DRAIN cycles 1-2, int_push=1 cycles 3-4 (int_word_sel 1 then 0), int_ack=1 at cycle 5 only.
REQ-040 Second int_req during PUSH_HI -> a second full sequence starts the cycle after IDLE; rst pulse mid-DRAIN -> all outputs 0, no int_ack.
REQ-041 Build without HAZARD_FWD_EN: mem_regWrite=1, mem_rdst=5, id_rsrc1=5, id_uses1=1 -> pc_stall=1; fwd_a=00.
